// File: rtl/enc_36_if.sv
// Start/done handshake and data bus shared by the 36-bit encrypt and decrypt cores.
interface enc_36_if;
    logic         encrypt_en;
    logic [35:0]  S_I;
    logic [143:0] keyin;
    logic [35:0]  S_j;
    logic         encr_done;
    logic         busy;
    logic [6:0]   round_no;

    modport master (
        output encrypt_en, S_I, keyin,
        input  S_j, encr_done, busy, round_no
    );

    modport slave (
        input  encrypt_en, S_I, keyin,
        output S_j, encr_done, busy, round_no
    );
endinterface

// File: rtl/enc_36_core.sv
// Iterative 36-bit block encryptor, 144-bit key, one round per clock (two with ENC_UNROLL2_EN).
// Optional macro: ENC_UNROLL2_EN chains two round datapaths per cycle; N_ROUNDS must then be even.
module enc_36_core #(
    parameter int N_ROUNDS = 10
) (
    input  logic    clk,
    input  logic    rst,
    enc_36_if.slave bus
);

`ifdef ENC_UNROLL2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    // state | meaning
    // IDLE  | waiting for encrypt_en, latches S_I/keyin on start
    // LOAD  | whitening with rk(0)
    // ROUND | STEP rounds per cycle until round N_ROUNDS
    // DONE  | ciphertext valid, held while encrypt_en stays high
    typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

    state_t       st, st_nxt;
    logic [35:0]  s_reg;
    logic [35:0]  s_j_reg;
    logic [143:0] key_reg;
    logic [6:0]   rnd;
    logic [35:0]  round_a;
    logic [35:0]  round_next;
    logic         last_round;

    // Forward sbox9: an odd-multiplier affine map over GF(2)/Z_512, hence a bijection.
    function automatic logic [8:0] sbox9(input logic [8:0] x);
        logic [8:0] t;
        t = x ^ 9'h0A5;
        return t * 9'd301 + 9'd87;
    endfunction

    function automatic logic [35:0] rotl36(input logic [35:0] x, input logic [5:0] amt);
        return (x << amt) | (x >> (6'd36 - amt));
    endfunction

    function automatic logic [35:0] rk(input logic [143:0] k, input logic [6:0] r);
        logic [35:0] ksel;
        logic [5:0]  amt;
        case (r[1:0])
            2'd0:    ksel = k[35:0];
            2'd1:    ksel = k[71:36];
            2'd2:    ksel = k[107:72];
            default: ksel = k[143:108];
        endcase
        amt = 6'(r % 7'd36);
        return rotl36(ksel, amt) ^ {r, 29'b0};
    endfunction

    function automatic logic [35:0] round_fn(input logic [35:0] s, input logic [143:0] k,
                                             input logic [6:0] r);
        logic [35:0] t;
        t = {sbox9(s[35:27]), sbox9(s[26:18]), sbox9(s[17:9]), sbox9(s[8:0])};
        t = {t[26:0], t[35:27]};
        if (r != 7'(N_ROUNDS)) begin
            t = {t[35:27], t[26:18] ^ t[35:27], t[17:9] ^ t[26:18], t[8:0] ^ t[17:9]};
        end
        return t ^ rk(k, r);
    endfunction

    always_comb begin
        round_a = round_fn(s_reg, key_reg, rnd);
`ifdef ENC_UNROLL2_EN
        round_next = round_fn(round_a, key_reg, rnd + 7'd1);
`else
        round_next = round_a;
`endif
    end

    assign last_round = (rnd == 7'(N_ROUNDS - STEP + 1));

    always_ff @(posedge clk) begin
        if (rst) st <= IDLE;
        else     st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:    if (bus.encrypt_en) st_nxt = LOAD;
            LOAD:    st_nxt = ROUND;
            ROUND:   if (last_round) st_nxt = DONE;
            DONE:    if (!bus.encrypt_en) st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg   <= '0;
            s_j_reg <= '0;
            key_reg <= '0;
            rnd     <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (bus.encrypt_en) begin
                        s_reg   <= bus.S_I;
                        key_reg <= bus.keyin;
                    end
                end
                LOAD: begin
                    s_reg <= s_reg ^ rk(key_reg, 7'd0);
                    rnd   <= 7'd1;
                end
                ROUND: begin
                    s_reg <= round_next;
                    rnd   <= rnd + 7'(STEP);
                    if (last_round) s_j_reg <= round_next;
                end
                DONE: begin
                    if (!bus.encrypt_en) rnd <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.S_j       = s_j_reg;
    assign bus.encr_done = (st == DONE);
    assign bus.busy      = (st == LOAD) || (st == ROUND);
    assign bus.round_no  = rnd;

endmodule

// File: tb/tb_enc_36_core.sv
// Self-checking bench for enc_36_core: table of vectors, randomized blocks, and a
// reference encrypt/decrypt model built from the round rules on word arrays.
module tb_enc_36_core;
    localparam int N = 10;
`ifdef ENC_UNROLL2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int LAT = N / STEP + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    enc_36_if bus ();
    enc_36_core #(.N_ROUNDS(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int tests = 0;
    int fails = 0;
    int sb[512];
    int isb[512];

    typedef struct {
        logic [35:0]  pt;
        logic [143:0] key;
        int           hold;
        logic [35:0]  exp_ct;
    } vec_t;
    vec_t        vt[8];
    logic [35:0] dut_ct[8];

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] m_rotl(input logic [35:0] x, input int a);
        logic [71:0] d;
        d = {x, x} << a;
        return d[71:36];
    endfunction

    function automatic logic [35:0] m_rk(input logic [143:0] key, input int r);
        logic [35:0] k;
        k = key[36*(r%4) +: 36];
        return m_rotl(k, r % 36) ^ (36'(r) << 29);
    endfunction

    function automatic logic [35:0] enc_model(input logic [35:0] pt, input logic [143:0] key);
        logic [35:0] s;
        logic [8:0]  u[4];
        logic [8:0]  n[4];
        s = pt ^ m_rk(key, 0);
        for (int r = 1; r <= N; r++) begin
            for (int i = 0; i < 4; i++) u[(i+1)%4] = 9'(sb[s[9*i +: 9]]);
            for (int i = 0; i < 4; i++) n[i] = (r < N && i < 3) ? (u[i] ^ u[i+1]) : u[i];
            s = {n[3], n[2], n[1], n[0]} ^ m_rk(key, r);
        end
        return s;
    endfunction

    function automatic logic [35:0] dec_model(input logic [35:0] ct, input logic [143:0] key);
        logic [35:0] s;
        logic [8:0]  u[4];
        logic [8:0]  w[4];
        s = ct;
        for (int r = N; r >= 1; r--) begin
            s = s ^ m_rk(key, r);
            for (int i = 0; i < 4; i++) u[i] = s[9*i +: 9];
            if (r < N) for (int i = 2; i >= 0; i--) u[i] = u[i] ^ u[i+1];
            for (int i = 0; i < 4; i++) w[i] = 9'(isb[u[(i+1)%4]]);
            s = {w[3], w[2], w[1], w[0]};
        end
        return s ^ m_rk(key, 0);
    endfunction

    // Called at a negedge with the DUT idle; the next posedge is the start edge.
    task automatic run_block(input logic [35:0] pt, input logic [143:0] key, input int hold,
                             input logic [35:0] exp, output logic [35:0] got);
        int j;
        bit rn_ok;
        bus.encrypt_en = 1'b1;
        bus.S_I        = pt;
        bus.keyin      = key;
        @(negedge clk);
        j = 0;
        rn_ok = 1'b1;
        check("load_busy", bus.busy, 1);
        if (hold == 0) bus.encrypt_en = 1'b0;
        while (!bus.encr_done && j < 40) begin
            @(negedge clk);
            j++;
            if (j == 2) begin
                bus.S_I   = 36'({$urandom(), $urandom()});
                bus.keyin = 144'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
            end
            if (bus.round_no !== 7'(1 + (j - 1) * STEP)) rn_ok = 1'b0;
        end
        got = bus.S_j;
        check("latency", j, LAT);
        check("round_no_seq", rn_ok, 1);
        check("ciphertext", bus.S_j, exp);
        check("round_trip", dec_model(bus.S_j, key), pt);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("done_held", bus.encr_done, 1);
            check("ct_held", bus.S_j, got);
        end
        bus.encrypt_en = 1'b0;
        @(negedge clk);
        check("done_cleared", bus.encr_done, 0);
        check("idle_state", {bus.busy, bus.round_no}, 8'h00);
        check("ct_kept_idle", bus.S_j, got);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [35:0] ct_mr;
        int          j;
        bit          quiet;

        for (int x = 0; x < 512; x++) begin
            sb[x] = (((x ^ 'h0A5) * 301) + 87) % 512;
            isb[sb[x]] = x;
        end

        vt[0] = '{36'h606AEBB19, 144'h0, 3, 36'h0};
        vt[1] = '{36'hAAAAAAAAA, {36{4'hA}}, 2, 36'h0};
        vt[2] = '{36'h123456789, 144'h0123456789ABCDEF0123456789ABCDEF0123, 0, 36'h0};
        for (int i = 3; i < 8; i++) begin
            vt[i].pt   = 36'({$urandom(), $urandom()});
            vt[i].key  = 144'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
            vt[i].hold = $urandom_range(0, 3);
        end
        for (int i = 0; i < 8; i++) vt[i].exp_ct = enc_model(vt[i].pt, vt[i].key);

        // Reset held with encrypt_en high: nothing may start.
        @(negedge clk);
        rst = 1'b1;
        bus.encrypt_en = 1'b1;
        bus.S_I = vt[0].pt;
        bus.keyin = vt[0].key;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("reset_outputs", {bus.S_j, bus.encr_done, bus.busy, bus.round_no}, 45'h0);
        end
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_block(vt[i].pt, vt[i].key, vt[i].hold, vt[i].exp_ct, dut_ct[i]);
        end
        check("pattern_key_differs", dut_ct[1] != dut_ct[0], 1);

        // Reset arriving mid-operation discards the block.
        bus.encrypt_en = 1'b1;
        bus.S_I = vt[2].pt;
        bus.keyin = vt[2].key;
        @(negedge clk);
        j = 0;
        while (bus.round_no !== 7'd5 && j < 20) begin
            @(negedge clk);
            j++;
        end
        check("reached_round5", bus.round_no, 5);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_outputs", {bus.S_j, bus.encr_done, bus.busy, bus.round_no}, 45'h0);
        rst = 1'b0;
        bus.encrypt_en = 1'b0;
        quiet = 1'b1;
        for (int c = 0; c < LAT + 3; c++) begin
            @(negedge clk);
            if (bus.encr_done || bus.busy) quiet = 1'b0;
        end
        check("no_done_after_reset", quiet, 1);
        run_block(vt[0].pt, vt[0].key, 1, vt[0].exp_ct, ct_mr);
        check("restart_matches_first", ct_mr, dut_ct[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
